// File: rtl/fetch_unit_pq.sv
// Instruction fetch front end: sequential PC requests, one outstanding at a time,
// with a DEPTH-entry prefetch queue of {pc, inst} and redirect/flush support.
module fetch_unit_pq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic                       o_req,
    output logic [XLEN-1:0]            o_addr,
    input  logic                       i_ready,
    input  logic [XLEN-1:0]            i_data,
    output logic                       o_valid,
    output logic [XLEN-1:0]            o_inst,
    output logic [XLEN-1:0]            o_pc,
    input  logic                       i_stall,
    input  logic                       i_redirect,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, empty_q;
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic [XLEN-1:0] redirect_pc;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after;

    assign redirect_pc = i_redirect_pc & ~XLEN'(3);
    assign pop         = (count_q != '0) && !i_stall;
    // A response arriving alongside a redirect belongs to the abandoned stream.
    assign push        = (state_q == StReq) && i_ready && !i_redirect;
    assign count_after = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            StIdle: begin
                if (i_redirect) begin
                    fpc_d = redirect_pc;
                end else if (count_q < DepthC) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (i_redirect) begin
                    fpc_d = redirect_pc;
                    if (i_ready) begin
                        state_d = StIdle;
                    end else begin
                        // Keep presenting the old address until memory answers.
                        drop_addr_d = fpc_q;
                        state_d     = StDrop;
                    end
                end else if (i_ready) begin
                    fpc_d = fpc_q + XLEN'(4);
                    if (count_after >= DepthC) begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                if (i_redirect) begin
                    fpc_d = redirect_pc;
                end
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_after;
        if (i_redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            fpc_q       <= PC_RESET;
            drop_addr_q <= PC_RESET;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DepthC);
            empty_q     <= (count_d == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= i_data;
            pc_mem_q[wr_ptr_q]   <= fpc_q;
        end
    end

    assign o_req   = (state_q != StIdle);
    assign o_addr  = (state_q == StDrop) ? drop_addr_q : fpc_q;
    assign o_valid = !empty_q;
    assign o_inst  = inst_mem_q[rd_ptr_q];
    assign o_pc    = pc_mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Directed bench for fetch_unit_pq: a memory responder checks request addresses and a
// monitor compares every consumed queue head against a scoreboard of expected entries.
module tb_fetch_unit_pq;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        i_clk;
    logic        i_rst;
    logic        o_req;
    logic [31:0] o_addr;
    logic        i_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_empty;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          budget;
    int          n_tests;
    int          n_fail;

    fetch_unit_pq #(
        .XLEN    (32),
        .PC_RESET(32'h0000_0100),
        .DEPTH   (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_req        (o_req),
        .o_addr       (o_addr),
        .i_ready      (i_ready),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_empty      (o_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Expected queue entry for a fetch of addr: memory returns addr ^ KEY.
    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.pc   = addr;
        e.inst = addr ^ KEY;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_valid && !i_stall) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_sb: unexpected head pc %h, required none", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", o_pc, e.pc);
                    chk("head_inst", o_inst, e.inst);
                end
            end
        end
    endtask

    // One clock: retire a pending redirect/ready pulse, then let memory answer if allowed.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (i_redirect) begin
            i_redirect = 1'b0;
            exp_q.delete();
        end
        if (i_ready) begin
            i_ready = 1'b0;
        end else if (o_req && budget > 0) begin
            budget--;
            if (addr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL addr_sb: unexpected request %h, required none", o_addr);
            end else begin
                chk("req_addr", o_addr, addr_q.pop_front());
            end
            i_ready = 1'b1;
            i_data  = o_addr ^ KEY;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(o_req),   32'd0);
        chk({tag, "_addr"},  o_addr,       32'h0000_0100);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
        chk({tag, "_empty"}, 32'(o_empty), 32'd1);
        chk({tag, "_full"},  32'(o_full),  32'd0);
        chk({tag, "_inst"},  o_inst,       32'd0);
        chk({tag, "_pc"},    o_pc,         32'd0);
    endtask

    initial begin
        i_rst = 1'b0;
        i_ready = 1'b0;
        i_data = '0;
        i_stall = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        budget = 0;
        n_tests = 0;
        n_fail = 0;
        fork
            monitor();
        join_none

        repeat (2) step();
        chk_reset_vals("rst");

        // Sequential fetch from PC_RESET
        i_rst = 1'b1;
        addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h108);
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        budget = 3;
        repeat (10) step();
        chk("t1_req_hold", 32'(o_req), 32'd1);
        chk("t1_next_addr", o_addr, 32'h10C);

        // Redirect to 0 while waiting, then fill under stall
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0;
        step();
        chk("t2_drop_addr", o_addr, 32'h10C);
        chk("t2_drop_req", 32'(o_req), 32'd1);
        i_stall = 1'b1;
        addr_q.push_back(32'h10C);
        for (int a = 0; a < 16; a += 4) begin
            addr_q.push_back(32'(a));
            push_exp(32'(a));
        end
        budget = 5;
        repeat (20) step();
        chk("t2_full", 32'(o_full), 32'd1);
        chk("t2_req_off", 32'(o_req), 32'd0);
        chk("t2_count", 32'(o_count), 32'd4);
        chk("t2_head_pc", o_pc, 32'h0);
        i_stall = 1'b0;
        addr_q.push_back(32'h10); addr_q.push_back(32'h14);
        push_exp(32'h10); push_exp(32'h14);
        budget = 2;
        repeat (20) step();
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_resume_addr", o_addr, 32'h18);

        // Redirect in REQ, late response must be dropped
        i_redirect = 1'b1;
        i_redirect_pc = 32'h2003;
        step();
        step();
        step();
        chk("t3_drop_addr", o_addr, 32'h18);
        i_ready = 1'b1;
        i_data = 32'hDEAD_BEEF;
        step();
        chk("t3_valid", 32'(o_valid), 32'd0);
        chk("t3_count", 32'(o_count), 32'd0);
        chk("t3_idle", 32'(o_req), 32'd0);
        step();
        chk("t3_new_addr", o_addr, 32'h2000);
        addr_q.push_back(32'h2000);
        push_exp(32'h2000);
        budget = 1;
        repeat (6) step();

        // Redirect coinciding with response and pop
        i_stall = 1'b1;
        addr_q.push_back(32'h2004);
        push_exp(32'h2004);
        budget = 1;
        repeat (6) step();
        chk("t4_count_pre", 32'(o_count), 32'd1);
        i_stall = 1'b0;
        i_ready = 1'b1;
        i_data = 32'h1111_1111;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h3000;
        step();
        chk("t4_count", 32'(o_count), 32'd0);
        chk("t4_valid", 32'(o_valid), 32'd0);
        chk("t4_idle", 32'(o_req), 32'd0);
        step();
        chk("t4_req", 32'(o_req), 32'd1);
        chk("t4_addr", o_addr, 32'h3000);

        // Address wrap at top of memory
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        step();
        addr_q.push_back(32'h3000); addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
        push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        budget = 3;
        repeat (12) step();
        chk("t5_addr", o_addr, 32'h4);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_addr_sb", 32'(addr_q.size()), 32'd0);

        // Asynchronous reset mid-cycle with a partly filled queue
        i_stall = 1'b1;
        addr_q.push_back(32'h4); addr_q.push_back(32'h8); addr_q.push_back(32'hC);
        budget = 3;
        repeat (10) step();
        chk("t6_count_pre", 32'(o_count), 32'd3);
        chk("t6_head_pre", o_pc, 32'h4);
        #2;
        i_rst = 1'b0;
        #1;
        chk_reset_vals("t6_async");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
